// File: rtl/load_store_sequencer.sv
// load_store_sequencer: turns byte/half/word CPU loads and stores into word-addressed memory
// transactions, doing read-modify-write for sub-word stores, with alignment and timeout checks.
module load_store_sequencer #(
  parameter int WORD_SIZE      = 32,
  parameter int MEMORY_SIZE    = 1000,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [1:0]           req_size,
  input  logic                 req_signed,
  input  logic [WORD_SIZE-1:0] req_addr,
  input  logic [WORD_SIZE-1:0] req_wdata,
  output logic                 resp_valid,
  output logic [WORD_SIZE-1:0] resp_rdata,
  output logic [1:0]           resp_err,
  output logic                 mem_start,
  output logic                 mem_write_enabled,
  output logic [WORD_SIZE-1:0] mem_address,
  output logic [WORD_SIZE-1:0] mem_input_data,
  input  logic                 mem_valid,
  input  logic [WORD_SIZE-1:0] mem_output_data,
  input  logic                 mem_err
);
  if (WORD_SIZE != 32 || TIMEOUT_CYCLES < 2 || MEMORY_SIZE < 1) begin : g_bad_params
    $error("load_store_sequencer: unsupported parameters");
  end
  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, RESP} state_t;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic wr_q, sgn_q, misalign;
  logic [1:0] size_q, off_q, err_nx;
  logic [4:0] sh;
  logic [15:0] lane_w;
  logic [31:0] wdata_q, lane, mask, merged, rdata_nx, din_nx;
  assign misalign = req_size == 2'd3 || (req_size == 2'd1 && req_addr[0]) ||
                    (req_size == 2'd2 && req_addr[1:0] != 2'd0);
  assign sh = {off_q, 3'b000};
  assign lane_w = 16'(mem_output_data >> sh);
  assign lane = size_q == 2'd0 ? {{24{sgn_q & lane_w[7]}}, lane_w[7:0]} :
                size_q == 2'd1 ? {{16{sgn_q & lane_w[15]}}, lane_w} : mem_output_data;
  assign mask = (size_q == 2'd0 ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
  assign merged = (mem_output_data & ~mask) | ((wdata_q << sh) & mask);
  assign req_ready = state == IDLE;
  assign resp_valid = state == RESP;
  assign mem_start = state == RD_ISSUE || state == WR_ISSUE;
  assign mem_write_enabled = state == WR_ISSUE;
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    err_nx = 2'd0;
    rdata_nx = '0;
    din_nx = mem_input_data;
    case (state)
      IDLE: if (req_valid) begin
        state_nx = misalign ? RESP : (req_write && req_size == 2'd2) ? WR_ISSUE : RD_ISSUE;
        err_nx = misalign ? 2'd1 : 2'd0;
        din_nx = req_wdata;
      end
      RD_ISSUE: begin
        state_nx = RD_WAIT;
        cnt_nx = '0;
      end
      WR_ISSUE: begin
        state_nx = WR_WAIT;
        cnt_nx = '0;
      end
      RD_WAIT, WR_WAIT: begin
        // error beats data; a failed read of a sub-word store never reaches the write
        if (mem_err) begin
          state_nx = RESP;
          err_nx = 2'd2;
        end else if (mem_valid && state == RD_WAIT && wr_q) begin
          state_nx = WR_ISSUE;
          din_nx = merged;
        end else if (mem_valid) begin
          state_nx = RESP;
          rdata_nx = state == RD_WAIT ? lane : '0;
        end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          state_nx = RESP;
          err_nx = 2'd3;
        end else cnt_nx = cnt + CW'(1);
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      wr_q <= 1'b0;
      sgn_q <= 1'b0;
      size_q <= 2'd0;
      off_q <= 2'd0;
      wdata_q <= '0;
      mem_address <= '0;
      mem_input_data <= '0;
      resp_rdata <= '0;
      resp_err <= 2'd0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      mem_input_data <= din_nx;
      resp_rdata <= rdata_nx;
      resp_err <= err_nx;
      if (req_valid && req_ready) begin
        wr_q <= req_write;
        sgn_q <= req_signed;
        size_q <= req_size;
        off_q <= req_addr[1:0];
        wdata_q <= req_wdata;
        mem_address <= {2'b00, req_addr[31:2]};
      end
    end
  end
endmodule

// File: tb/tb_load_store_sequencer.sv
// tb_load_store_sequencer: memory stub plus an arithmetic reference model of byte-lane
// loads/stores, driving directed and random requests through the sequencer.
module tb_load_store_sequencer;
  localparam int MS = 1000;
  localparam int T = 16;
  logic clock = 0, reset_n = 0;
  logic req_valid = 0, req_write = 0, req_signed = 0;
  logic [1:0] req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic req_ready, resp_valid, mem_start, mem_write_enabled, mem_valid, mem_err;
  logic [1:0] resp_err;
  logic [31:0] resp_rdata, mem_address, mem_input_data, mem_output_data;
  int n_chk = 0, n_pass = 0;

  load_store_sequencer #(.WORD_SIZE(32), .MEMORY_SIZE(MS), .TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_start(mem_start), .mem_write_enabled(mem_write_enabled), .mem_address(mem_address),
    .mem_input_data(mem_input_data), .mem_valid(mem_valid), .mem_output_data(mem_output_data),
    .mem_err(mem_err));

  always #5 clock = ~clock;

  // memory stub: answers k cycles into the wait, or never when silent; ignores reset
  logic [31:0] mem [MS];
  logic [31:0] ref_mem [MS];
  int cd = 0, k = 1, starts = 0, writes = 0;
  bit silent = 0;
  logic [31:0] sa = 0, sd = 0, start_addr = 0;
  logic swe = 0;
  always @(posedge clock) begin
    if (mem_start) begin
      sa <= mem_address;
      sd <= mem_input_data;
      swe <= mem_write_enabled;
      start_addr <= mem_address;
      cd <= silent ? 0 : k;
      starts <= starts + 1;
      writes <= writes + (mem_write_enabled ? 1 : 0);
    end else if (cd > 0) cd <= cd - 1;
    if (cd == 1 && swe && sa < MS) mem[sa[9:0]] <= sd;
  end
  assign mem_valid = cd == 1 && sa < MS;
  assign mem_err = cd == 1 && sa >= MS;
  assign mem_output_data = sa < MS ? mem[sa[9:0]] : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                        input logic [31:0] wd, input int kk, input bit quiet, output logic [31:0] got);
    logic [31:0] wa, exp_rd;
    logic [1:0] exp_err;
    int off, nb, n, s0, w0, exp_lat, exp_st, exp_wr;
    longint lm, old, lv, nv;
    bit mis, upd;
    wa = a >> 2;
    off = int'(a[1:0]);
    nb = 1 << sz;
    mis = sz == 2'd3 || (sz == 2'd1 && off % 2 != 0) || (sz == 2'd2 && off != 0);
    exp_rd = 0;
    exp_err = 0;
    exp_st = 1;
    exp_wr = 0;
    exp_lat = kk + 2;
    upd = 0;
    if (mis) begin
      exp_err = 1;
      exp_lat = 1;
      exp_st = 0;
    end else if (wa >= MS || quiet) begin
      exp_err = wa >= MS ? 2'd2 : 2'd3;
      exp_lat = wa >= MS ? kk + 2 : T + 2;
      exp_wr = (w && nb == 4) ? 1 : 0;
    end else begin
      lm = 64'd1 << (8 * nb);
      old = longint'(ref_mem[wa[9:0]]);
      lv = (old >> (8 * off)) % lm;
      if (!w) begin
        if (sg && nb < 4 && lv >= lm / 2) lv = lv + 64'h1_0000_0000 - lm;
        exp_rd = lv[31:0];
      end else begin
        nv = old - (lv << (8 * off)) + ((longint'(wd) % lm) << (8 * off));
        ref_mem[wa[9:0]] = nv[31:0];
        exp_wr = 1;
        upd = 1;
        if (nb < 4) begin
          exp_st = 2;
          exp_lat = 2 * kk + 3;
        end
      end
    end
    k = kk;
    silent = quiet;
    @(posedge clock);
    #1;
    check("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_write = w;
    req_size = sz;
    req_signed = sg;
    req_addr = a;
    req_wdata = wd;
    req_valid = 1;
    s0 = starts;
    w0 = writes;
    @(posedge clock);
    #1;
    req_valid = 0;
    n = 1;
    while (!resp_valid && n < 300) begin
      @(posedge clock);
      #1;
      n++;
    end
    got = resp_rdata;
    check("latency", n, exp_lat);
    check("resp_err", {30'b0, resp_err}, {30'b0, exp_err});
    check("resp_rdata", resp_rdata, exp_rd);
    check("mem_starts", starts - s0, exp_st);
    check("mem_writes", writes - w0, exp_wr);
    if (exp_st > 0) check("mem_address", start_addr, wa);
    if (upd) check("mem_word", mem[wa[9:0]], ref_mem[wa[9:0]]);
    silent = 0;
  endtask

  initial begin
    logic [31:0] g, a;
    int rv;
    for (int i = 0; i < MS; i++) ref_mem[i] = 0;
    #2;
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_mem_start", {31'b0, mem_start}, 32'd0);
    check("rst_mem_we", {31'b0, mem_write_enabled}, 32'd0);
    check("rst_mem_address", mem_address, 32'd0);
    check("rst_resp_err", {30'b0, resp_err}, 32'd0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1;
    do_req(1, 2, 0, 32'h320, 32'hC9, 2, 0, g);
    do_req(0, 2, 0, 32'h320, 0, 3, 0, g);
    check("t1_rdata", g, 32'hC9);
    check("t1_addr", start_addr, 32'hC8);
    do_req(1, 2, 0, 32'h10, 32'hAABBCCDD, 1, 0, g);
    do_req(1, 0, 0, 32'h11, 32'h55, 2, 0, g);
    do_req(0, 2, 0, 32'h10, 0, 1, 0, g);
    check("t2_merged", g, 32'hAABB55DD);
    do_req(0, 0, 1, 32'h11, 0, 1, 0, g);
    check("t2_sbyte", g, 32'h0000_0055);
    do_req(0, 1, 1, 32'h12, 0, 2, 0, g);
    check("t2_shalf", g, 32'hFFFF_AABB);
    do_req(0, 1, 0, 32'h3, 0, 1, 0, g);
    do_req(1, 2, 0, 32'h2, 32'h1234, 1, 0, g);
    do_req(0, 3, 0, 32'h8, 0, 1, 0, g);
    do_req(0, 2, 0, 4 * MS, 0, 2, 0, g);
    do_req(0, 2, 0, 32'hFFFF_FFFC, 0, 1, 0, g);
    do_req(1, 0, 0, 4 * MS, 32'h77, 1, 0, g);
    do_req(0, 2, 0, 32'h320, 0, 1, 1, g);
    do_req(0, 2, 0, 32'h320, 0, 1, 0, g);
    check("t5_recover", g, 32'hC9);
    // reset in the middle of a slow read; the stub still answers after release
    k = 10;
    @(posedge clock);
    #1;
    req_write = 0;
    req_size = 2;
    req_addr = 32'h320;
    req_valid = 1;
    @(posedge clock);
    #1 req_valid = 0;
    repeat (3) @(posedge clock);
    #3 reset_n = 0;
    #1;
    check("t6_rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("t6_rst_mem_start", {31'b0, mem_start}, 32'd0);
    check("t6_rst_mem_address", mem_address, 32'd0);
    check("t6_rst_req_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clock);
    #1 reset_n = 1;
    @(posedge clock);
    #1;
    check("t6_ready_after", {31'b0, req_ready}, 32'd1);
    rv = 0;
    repeat (12) begin
      @(posedge clock);
      #1;
      rv += resp_valid ? 1 : 0;
    end
    check("t6_no_stale_resp", rv, 0);
    for (int i = 0; i < 16; i++) do_req(1, 2, 0, 4 * i, $urandom, $urandom_range(1, 3), 0, g);
    for (int i = 0; i < 80; i++) begin
      a = $urandom_range(0, 9) == 0 ? 4 * (MS + $urandom_range(0, 3)) : 4 * $urandom_range(0, 15);
      a = a + $urandom_range(0, 3);
      do_req(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom,
             $urandom_range(1, 4), 0, g);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
